// File: rtl/mmio_pkg.sv
// Shared types for the MMIO bus arbiter: FSM states, master ids and limits.
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_t;

    localparam int RD_LAT_MAX = 7;
    localparam int CNT_W      = 3;

    function automatic master_t other_master(input master_t m);
        return (m == M0) ? M1 : M0;
    endfunction

    function automatic logic [1:0] master_onehot(input master_t m);
        return (m == M1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the master
// that did not own the bus last.
module rr_arbiter2
    import mmio_pkg::*;
(
    input  logic [1:0] req_i,
    input  master_t    last_i,
    output logic [1:0] gnt_o,
    output master_t    idx_o
);

    always_comb begin
        idx_o = M0;
        case (req_i)
            2'b01:   idx_o = M0;
            2'b10:   idx_o = M1;
            2'b11:   idx_o = other_master(last_i);
            default: idx_o = M0;
        endcase
        gnt_o = (req_i != 2'b00) ? master_onehot(idx_o) : 2'b00;
    end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Shares the MMIO device bus between the CPU port (M0) and the loader/DMA
// port (M1); one transaction in flight, fixed device read latency.
module mmio_bus_arbiter
    import mmio_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int AW     = 32,
    parameter int DW     = 32
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
    input  logic [3:0]    m0_wmask_i,
    output logic          m0_gnt_o,
    output logic          m0_done_o,
    output logic [DW-1:0] m0_rdata_o,
    output logic          m0_err_o,

    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
    input  logic [3:0]    m1_wmask_i,
    output logic          m1_gnt_o,
    output logic          m1_done_o,
    output logic [DW-1:0] m1_rdata_o,
    output logic          m1_err_o,

    output logic          bus_valid_o,
    output logic          bus_we_o,
    output logic [AW-1:0] bus_addr_o,
    output logic [DW-1:0] bus_wdata_o,
    output logic [3:0]    bus_wmask_o,
    input  logic [DW-1:0] bus_rdata_i,
    input  logic          bus_hit_i
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

    arb_state_t      state_q;
    master_t         owner_q, last_q;
    logic            we_q, err_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q, rdata_q;
    logic [3:0]      wmask_q;
    logic [CNT_W-1:0] cnt_q;
    logic            bus_valid_q, bus_we_q;
    logic [1:0]      done_q;

    logic [1:0]      arb_gnt;
    master_t         arb_idx;
    logic            sel_we_d;
    logic [AW-1:0]   sel_addr_d;
    logic [DW-1:0]   sel_wdata_d;
    logic [3:0]      sel_wmask_d;

    rr_arbiter2 u_rr (
        .req_i  ({m1_req_i, m0_req_i}),
        .last_i (last_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx)
    );

    always_comb begin
        sel_we_d    = m0_we_i;
        sel_addr_d  = m0_addr_i;
        sel_wdata_d = m0_wdata_i;
        sel_wmask_d = m0_wmask_i;
        if (arb_idx == M1) begin
            sel_we_d    = m1_we_i;
            sel_addr_d  = m1_addr_i;
            sel_wdata_d = m1_wdata_i;
            sel_wmask_d = m1_wmask_i;
        end
    end

    // The grant is the only combinational path from a requester; it is
    // only meaningful while IDLE, where requests are sampled.
    assign m0_gnt_o = (state_q == IDLE) & arb_gnt[0];
    assign m1_gnt_o = (state_q == IDLE) & arb_gnt[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= M0;
            last_q      <= M1;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            done_q      <= 2'b00;
        end else begin
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            done_q      <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (arb_gnt != 2'b00) begin
                        owner_q     <= arb_idx;
                        last_q      <= arb_idx;
                        we_q        <= sel_we_d;
                        addr_q      <= sel_addr_d;
                        wdata_q     <= sel_wdata_d;
                        wmask_q     <= sel_wmask_d;
                        err_q       <= 1'b0;
                        rdata_q     <= '0;
                        bus_valid_q <= 1'b1;
                        bus_we_q    <= sel_we_d;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    err_q <= ~bus_hit_i;
                    if (we_q) begin
                        done_q  <= master_onehot(owner_q);
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= CNT_INIT;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        // Unmapped reads must not leak whatever the decoder mux shows.
                        rdata_q <= err_q ? '0 : bus_rdata_i;
                        done_q  <= master_onehot(owner_q);
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_valid_o = bus_valid_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign bus_wmask_o = wmask_q;

    assign m0_done_o  = done_q[0];
    assign m1_done_o  = done_q[1];
    assign m0_err_o   = done_q[0] & err_q;
    assign m1_err_o   = done_q[1] & err_q;
    assign m0_rdata_o = done_q[0] ? rdata_q : '0;
    assign m1_rdata_o = done_q[1] ? rdata_q : '0;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Scoreboard bench for mmio_bus_arbiter: drivers queue expectations, a
// negedge monitor pops and checks grants, bus strobes and done pulses.
module tb_mmio_bus_arbiter;
    import mmio_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic [3:0]    m0_wmask = '0, m1_wmask = '0;
    logic          m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          bus_valid, bus_we, bus_hit;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata, bus_rdata;
    logic [3:0]    bus_wmask;

    // Device side: two mapped 1 MiB windows, data = addr ^ 0x00301234.
    function automatic logic dec_hit(input logic [AW-1:0] a);
        return (a[31:20] == 12'h001) || (a[31:20] == 12'h003);
    endfunction
    function automatic logic [DW-1:0] dev_rd(input logic [AW-1:0] a);
        return dec_hit(a) ? (a ^ 32'h0030_1234) : 32'hBAD0_BAD0;
    endfunction

    assign bus_hit   = dec_hit(bus_addr);
    assign bus_rdata = dev_rd(bus_addr);

    mmio_bus_arbiter #(.RD_LAT(1), .AW(AW), .DW(DW)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_wmask_i(m0_wmask), .m0_gnt_o(m0_gnt), .m0_done_o(m0_done), .m0_rdata_o(m0_rdata),
        .m0_err_o(m0_err),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_wmask_i(m1_wmask), .m1_gnt_o(m1_gnt), .m1_done_o(m1_done), .m1_rdata_o(m1_rdata),
        .m1_err_o(m1_err),
        .bus_valid_o(bus_valid), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
        .bus_wdata_o(bus_wdata), .bus_wmask_o(bus_wmask),
        .bus_rdata_i(bus_rdata), .bus_hit_i(bus_hit)
    );

    // Second instance with a 3-cycle device latency, M1 idle.
    logic          r_req = 0;
    logic [AW-1:0] r_addr = '0;
    logic          r_gnt, r_done, r_err, r_g1, r_d1, r_e1;
    logic [DW-1:0] r_rdata, r_rd1;
    logic          r_valid, r_we, r_hit;
    logic [AW-1:0] r_bus_addr;
    logic [DW-1:0] r_bus_wdata, r_bus_rdata;
    logic [3:0]    r_bus_wmask;
    logic          z1 = 1'b0;
    logic [AW-1:0] za = '0;
    logic [DW-1:0] zd = '0;
    logic [3:0]    zm = '0;

    assign r_hit       = dec_hit(r_bus_addr);
    assign r_bus_rdata = dev_rd(r_bus_addr);

    mmio_bus_arbiter #(.RD_LAT(3), .AW(AW), .DW(DW)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(r_req), .m0_we_i(z1), .m0_addr_i(r_addr), .m0_wdata_i(zd),
        .m0_wmask_i(zm), .m0_gnt_o(r_gnt), .m0_done_o(r_done), .m0_rdata_o(r_rdata),
        .m0_err_o(r_err),
        .m1_req_i(z1), .m1_we_i(z1), .m1_addr_i(za), .m1_wdata_i(zd),
        .m1_wmask_i(zm), .m1_gnt_o(r_g1), .m1_done_o(r_d1), .m1_rdata_o(r_rd1),
        .m1_err_o(r_e1),
        .bus_valid_o(r_valid), .bus_we_o(r_we), .bus_addr_o(r_bus_addr),
        .bus_wdata_o(r_bus_wdata), .bus_wmask_o(r_bus_wmask),
        .bus_rdata_i(r_bus_rdata), .bus_hit_i(r_hit)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    wmask;
    } bus_exp_t;

    typedef struct {
        logic          m;
        logic          err;
        logic [DW-1:0] rdata;
        int            lat;
    } done_exp_t;

    logic      gnt_q[$];
    bus_exp_t  bus_q[$];
    done_exp_t done_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expire(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Monitor
    int        gnt_cyc = 0;
    logic      ge;
    bus_exp_t  be;
    done_exp_t de;

    always @(negedge clk) begin
        if (rst_n) begin
            if (m0_gnt || m1_gnt) begin
                chk("gnt_onehot", {63'd0, m0_gnt & m1_gnt}, 64'd0);
                if (gnt_q.size() == 0) chk("gnt_unexpected", {63'd0, m1_gnt}, {63'd0, ~m1_gnt});
                else begin
                    ge = gnt_q.pop_front();
                    chk("gnt_master", {63'd0, m1_gnt}, {63'd0, ge});
                end
                gnt_cyc = cyc;
            end
            if (bus_we && !bus_valid) chk("bus_we_without_valid", {63'd0, bus_we}, 64'd0);
            if (bus_valid) begin
                chk("bus_valid_timing", 64'(cyc - gnt_cyc), 64'd1);
                if (bus_q.size() == 0) chk("bus_unexpected", {63'd0, bus_valid}, 64'd0);
                else begin
                    be = bus_q.pop_front();
                    chk("bus_we",    {63'd0, bus_we}, {63'd0, be.we});
                    chk("bus_addr",  64'(bus_addr),   64'(be.addr));
                    chk("bus_wdata", 64'(bus_wdata),  64'(be.wdata));
                    chk("bus_wmask", 64'(bus_wmask),  64'(be.wmask));
                end
            end
            if (m0_done || m1_done) begin
                chk("done_onehot", {63'd0, m0_done & m1_done}, 64'd0);
                if (done_q.size() == 0) chk("done_unexpected", {62'd0, m1_done, m0_done}, 64'd0);
                else begin
                    de = done_q.pop_front();
                    chk("done_master", {63'd0, m1_done}, {63'd0, de.m});
                    chk("done_err",   {63'd0, de.m ? m1_err : m0_err}, {63'd0, de.err});
                    chk("done_rdata", 64'(de.m ? m1_rdata : m0_rdata), 64'(de.rdata));
                    chk("done_latency", 64'(cyc - gnt_cyc), 64'(de.lat));
                    chk("other_master_quiet",
                        de.m ? {30'd0, m0_done, m0_err, m0_rdata} : {30'd0, m1_done, m1_err, m1_rdata},
                        64'd0);
                end
            end
        end
    end

    task automatic drive(input logic m, input logic req, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [3:0] wm);
        if (m) begin m1_we = we; m1_addr = a; m1_wdata = wd; m1_wmask = wm; m1_req = req; end
        else   begin m0_we = we; m0_addr = a; m0_wdata = wd; m0_wmask = wm; m0_req = req; end
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (m0_done || m1_done) begin ok = 1; break; end
        end
        if (!ok) expire("done_wait");
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic m, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [3:0] wm,
                         input logic exp_err, input logic [DW-1:0] exp_rd, input int lat);
        bit ok = 0;
        gnt_q.push_back(m);
        bus_q.push_back('{we, a, wd, wm});
        done_q.push_back('{m, exp_err, exp_rd, lat});
        drive(m, 1'b1, we, a, wd, wm);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m ? m1_gnt : m0_gnt) begin ok = 1; break; end
        end
        if (!ok) expire("gnt_wait");
        @(posedge clk); #1;
        drive(m, 1'b0, we, a, wd, wm);
        wait_done();
    endtask

    // Both masters hold write requests through n grants; expect strict alternation.
    task automatic both_alt(input int n);
        int got = 0;
        int prev = 0;
        for (int k = 0; k < n; k++) begin
            if (k % 2 == 0) begin
                gnt_q.push_back(1'b0);
                bus_q.push_back('{1'b1, 32'h0010_0010, 32'h0A0A_0A0A, 4'h3});
                done_q.push_back('{1'b0, 1'b0, 32'h0, 2});
            end else begin
                gnt_q.push_back(1'b1);
                bus_q.push_back('{1'b1, 32'h0030_0020, 32'h0B0B_0B0B, 4'hC});
                done_q.push_back('{1'b1, 1'b0, 32'h0, 2});
            end
        end
        drive(1'b0, 1'b1, 1'b1, 32'h0010_0010, 32'h0A0A_0A0A, 4'h3);
        drive(1'b1, 1'b1, 1'b1, 32'h0030_0020, 32'h0B0B_0B0B, 4'hC);
        for (int i = 0; i < 60 && got < n; i++) begin
            @(negedge clk);
            if (m0_gnt || m1_gnt) begin
                if (got > 0) chk("gnt_spacing", 64'(cyc - prev), 64'd3);
                prev = cyc;
                got++;
            end
        end
        if (got < n) expire("alt_gnt_wait");
        @(posedge clk); #1;
        m0_req = 0;
        m1_req = 0;
        wait_done();
    endtask

    initial begin
        int g;
        rst_n = 0;
        repeat (2) @(negedge clk);
        chk("rst_outputs",
            {50'd0, m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, bus_valid, bus_we, 4'(bus_wmask), 2'd0},
            64'd0);
        chk("rst_bus_addr", 64'(bus_addr), 64'd0);
        chk("rst_bus_wdata", 64'(bus_wdata), 64'd0);
        chk("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1;

        both_alt(4);
        issue(1'b0, 1'b1, 32'h0010_0004, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,         2);
        issue(1'b1, 1'b0, 32'h0030_0000, 32'h0,         4'h0, 1'b0, 32'h0000_1234, 3);
        issue(1'b0, 1'b0, 32'h0010_0008, 32'h0,         4'h0, 1'b0, 32'h0020_123C, 3);
        issue(1'b1, 1'b0, 32'h00A0_0000, 32'h0,         4'h0, 1'b1, 32'h0,         3);
        issue(1'b0, 1'b1, 32'h00A0_0004, 32'h0000_0055, 4'h1, 1'b1, 32'h0,         2);

        // M0 read cut off by reset while in WAIT: no done, last reverts to M1.
        gnt_q.push_back(1'b0);
        bus_q.push_back('{1'b0, 32'h0030_0008, 32'h0, 4'h0});
        drive(1'b0, 1'b1, 1'b0, 32'h0030_0008, 32'h0, 4'h0);
        begin
            bit ok = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (m0_gnt) begin ok = 1; break; end
            end
            if (!ok) expire("rst_gnt_wait");
        end
        @(posedge clk); #1;
        m0_req = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("rst_wait_quiet", {60'd0, m0_done, m1_done, bus_valid, bus_we}, 64'd0);
        chk("rst_wait_addr", 64'(bus_addr), 64'd0);
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_done_after_rst", {62'd0, m1_done, m0_done}, 64'd0);
        end
        @(posedge clk); #1;
        both_alt(2);

        // RD_LAT=3 instance: done 5 cycles after grant, address held meanwhile.
        r_addr = 32'h0030_0000;
        r_req = 1;
        @(negedge clk);
        chk("r3_gnt", {63'd0, r_gnt}, 64'd1);
        g = cyc;
        @(posedge clk); #1;
        r_req = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("r3_addr_hold", 64'(r_bus_addr), 64'h0030_0000);
            chk("r3_no_early_done", {63'd0, r_done}, 64'd0);
        end
        @(negedge clk);
        chk("r3_done", {63'd0, r_done}, 64'd1);
        chk("r3_latency", 64'(cyc - g), 64'd5);
        chk("r3_rdata", 64'(r_rdata), 64'h1234);
        chk("r3_err", {63'd0, r_err}, 64'd0);

        repeat (3) @(negedge clk);
        chk("sb_leftover", 64'(gnt_q.size() + bus_q.size() + done_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
